// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;
  localparam int DIV_W     = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [DIV_W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         qbit
);
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       carry;

  assign shifted = {rem, msb};
  // subtract as add-of-complement: carry out set means no borrow
  assign {carry, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (W+2)'(1);
  assign qbit     = carry;
  assign rem_next = W'(carry ? diff : shifted);
endmodule

// File: rtl/unit_div.sv
// rtl/unit_div.sv - 32-bit signed/unsigned restoring divider with start/valid/ack handshake
module unit_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             N,
  output logic             Z,
  output logic             DZ,
  output logic             O
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             q_neg, r_neg, ovf;

  logic [WIDTH-1:0] a_abs, b_abs, rem_next, q_fix, r_fix;
  logic             qbit;

  assign a_abs = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_abs = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign q_fix = q_neg ? (~dvd + 1'b1) : dvd;
  assign r_fix = r_neg ? (~rem + 1'b1) : rem;

  div_step #(.W(WIDTH)) u_step (
    .rem      (rem),
    .msb      (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      q     <= '0;
      r     <= '0;
      N     <= 1'b0;
      Z     <= 1'b0;
      DZ    <= 1'b0;
      O     <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (b == '0) begin
              // divide-by-zero skips the loop and publishes on this edge
              q     <= DZ_QUOT;
              r     <= a;
              N     <= DZ_QUOT[WIDTH-1];
              Z     <= 1'b0;
              DZ    <= 1'b1;
              O     <= 1'b0;
              valid <= 1'b1;
              state <= DONE;
            end else begin
              dvd   <= a_abs;
              dvs   <= b_abs;
              rem   <= '0;
              cnt   <= '0;
              q_neg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg <= sgn && a[WIDTH-1];
              ovf   <= sgn && (a == MIN_NEG) && (b == '1);
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], qbit};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(DIV_STEPS - 1)) state <= FIX;
        end
        FIX: begin
          q     <= q_fix;
          r     <= r_fix;
          N     <= q_fix[WIDTH-1];
          Z     <= (q_fix == '0);
          DZ    <= 1'b0;
          O     <= ovf;
          valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (ack) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unit_div.sv
// tb/tb_unit_div.sv - directed scoreboard bench for unit_div
module tb_unit_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ack = 1'b0;
  logic        ready, valid, N, Z, DZ, O;
  logic [31:0] q, r;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        dz;
    logic        o;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  unit_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .ready (ready),
    .valid (valid),
    .ack   (ack),
    .q     (q),
    .r     (r),
    .N     (N),
    .Z     (Z),
    .DZ    (DZ),
    .O     (O)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    e.dz  = 1'b0;
    e.o   = 1'b0;
    e.lat = 32'd34;
    if (y == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = x;
      e.dz  = 1'b1;
      e.lat = 32'd1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
      e.o = 1'b1;
    end else if (s) begin
      e.q = $signed(x) / $signed(y);
      e.r = $signed(x) % $signed(y);
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    e.n = e.q[31];
    e.z = (e.q == 32'd0);
    return e;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_q"}, q, 0);
    check({tag, "_r"}, r, 0);
    check({tag, "_flags"}, {N, Z, DZ, O}, 0);
  endtask

  task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int hold, input bit poke, input bit ack_start);
    exp_t e;
    int   lat;
    @(negedge clk);
    start = 1'b1; a = x; b = y; sgn = s;
    sb.push_back(model(x, y, s));
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sgn = $urandom_range(0, 1);
    check("ready_drop", ready, 0);
    lat = 1;
    while (!valid && lat < 100) begin
      start = (poke && lat == 5);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("busy_not_ready", ready, 0);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("q", q, e.q);
    check("r", r, e.r);
    check("flags_nzdo", {N, Z, DZ, O}, {e.n, e.z, e.dz, e.o});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", valid, 1);
      check("hold_qr", {q, r}, {e.q, e.r});
    end
    ack = 1'b1;
    if (ack_start) begin
      start = 1'b1; a = 32'd50; b = 32'd5; sgn = 1'b0;
    end
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    check("ack_ready", ready, 1);
    check("ack_valid", valid, 0);
    if (ack_start) begin
      @(negedge clk);
      check("start_with_ack_not_taken", ready, 1);
    end
  endtask

  initial begin
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("post_reset");

    run_div(32'd100, 32'd7, 1'b0, 10, 1'b0, 1'b0);
    run_div(-32'sd7, 32'd2, 1'b1, 0, 1'b0, 1'b0);
    run_div(32'd7, -32'sd2, 1'b1, 0, 1'b1, 1'b0);
    run_div(32'h1234, 32'd0, 1'b0, 3, 1'b0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b1);
    run_div(32'd5, 32'd9, 1'b0, 0, 1'b0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_div($urandom, $urandom_range(1, 32'h0001_0000), 1'(k % 2), 0, 1'b0, 1'b0);
    end

    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("mid_div_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_ready", ready, 1);
    run_div(32'd9, 32'd3, 1'b0, 0, 1'b0, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
